eu_multicycle_ctrl: RTL and testbench
=====================================

// Module: eu_multicycle_ctrl
// PURPOSE
//  Multicycle control FSM for the CPU execution unit. Sequences fetch/decode/execute/memory/writeback.
//  Drives the immediate-extend select for the 16->32 immediate path: sign, zero or upper-half.
//  Arbitrates the single memory port between instruction fetch and data access with a req/ack handshake.
//  Sits between the instruction register (opcode/funct) and the EU datapath muxes and enables.
// PARAMETERS
//  RESET_PC_SEL  0  PC source select driven in S_IDLE (0 = PC+4 path).
//  CNT_W         32 width of the retired-instruction counter (PERF_CNT_EN only).
// PORTS
//  clk         in   1   rising-edge clock
//  reset_n     in   1   asynchronous, active-low reset
//  Opcode      in   6   IR[31:26], valid from S_DECODE onward
//  Funct       in   6   IR[5:0], R-type only
//  ALU_Zero    in   1   ALU zero flag
//  Mem_Ack     in   1   memory done; one-cycle pulse
//  Mem_Req     out  1   memory request; held high until the Mem_Ack cycle
//  Mem_Wr      out  1   1 = store, 0 = read; valid while Mem_Req=1
//  IorD        out  1   memory address: 0 = PC, 1 = ALUOut
//  IR_Wr       out  1   load instruction register
//  PC_Wr       out  1   unconditional PC write
//  PC_WrCond   out  1   branch PC write, already qualified by ALU_Zero and beq/bne
//  PC_Src      out  2   0 = ALU (PC+4), 1 = ALUOut (branch target), 2 = jump address
//  ALU_SrcA    out  1   0 = PC, 1 = register A
//  ALU_SrcB    out  2   0 = B, 1 = const 4, 2 = extended imm, 3 = extended imm<<2
//  ALU_Op      out  2   0 = add, 1 = sub, 2 = use Funct, 3 = use Opcode (imm ALU ops)
//  Ext_Sel     out  2   0 = sign-extend, 1 = zero-extend, 2 = {imm,16'h0}
//  Reg_Wr      out  1   register file write enable
//  Reg_Dst     out  1   0 = rt, 1 = rd
//  MemToReg    out  1   0 = ALUOut, 1 = MDR
//  Halted      out  1   illegal opcode trapped
// BEHAVIOUR
//  - Reset: state S_IDLE; Ext_Sel=0; every output 0. S_IDLE moves to S_FETCH on the next clock.
//  - Outputs are Moore, decoded from the state register. Exceptions: Ext_Sel is a register;
//    PC_WrCond also uses ALU_Zero.
//  - S_FETCH: Mem_Req=1, IorD=0, ALU_SrcA=0, ALU_SrcB=1, ALU_Op=0.
//    On the Mem_Ack cycle: IR_Wr=1, PC_Wr=1, PC_Src=0, then go to S_DECODE.
//    Without Mem_Ack, stay in S_FETCH and keep Mem_Req high.
//  - S_DECODE: ALU_SrcA=0, ALU_SrcB=3 (branch target). Ext_Sel registered from Opcode and held
//    until the next S_DECODE:
//      sign: 08 addi, 0A slti, 23 lw, 2B sw, 04 beq, 05 bne
//      zero: 0C andi, 0D ori, 0E xori
//      upper: 0F lui
//      all others: Ext_Sel unchanged
//  - Transitions from S_DECODE:
//      00 -> S_RX; imm ops -> S_IX; 23/2B -> S_ADDR; 04/05 -> S_BR; 02 -> S_JMP;
//      any other opcode -> S_HALT
//  - S_RX: ALU_SrcA=1, ALU_SrcB=0, ALU_Op=2 -> S_RWB (Reg_Wr=1, Reg_Dst=1, MemToReg=0) -> S_FETCH.
//  - S_IX: ALU_SrcA=1, ALU_SrcB=2, ALU_Op=3 -> S_IWB (Reg_Wr=1, Reg_Dst=0) -> S_FETCH.
//  - S_ADDR: ALU_SrcA=1, ALU_SrcB=2, ALU_Op=0 -> S_MEM.
//  - S_MEM: Mem_Req=1, IorD=1, Mem_Wr = (Opcode==2B). Wait for Mem_Ack.
//    On ack: sw -> S_FETCH; lw -> S_LWB (Reg_Wr=1, MemToReg=1, Reg_Dst=0) -> S_FETCH.
//  - S_BR: ALU_SrcA=1, ALU_SrcB=0, ALU_Op=1, PC_Src=1.
//    PC_WrCond = beq ? ALU_Zero : ~ALU_Zero. Always -> S_FETCH.
//  - S_JMP: PC_Wr=1, PC_Src=2 -> S_FETCH.
//  - S_HALT: Halted=1, every other output 0; stays there until reset_n is asserted.
//  - Latency in cycles, with Mem_Ack arriving in the first request cycle:
//    R/imm 4, beq/bne/j 3, sw 4, lw 5.
//  - Mem_Ack while Mem_Req=0 is ignored. reset_n asserted mid-access drops Mem_Req in the same
//    cycle (asynchronous reset); no pending request survives reset.
//  - Unknown Funct in S_RX is not trapped; Funct is passed through to the ALU control.
// CONFIGURATION
//  - PERF_CNT_EN defined: adds output Retired[CNT_W-1:0], reset 0.
//    It increments by 1 on every transition into S_FETCH from a non-IDLE state, wraps modulo 2^CNT_W,
//    and freezes in S_HALT.
//  - PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Package eu_ctrl_pkg: state encoding (4-bit localparams), opcode constants,
//    Ext_Sel / ALU_Op / PC_Src / ALU_SrcB encodings.
//  - One sub-module, eu_ext_sel_decode: combinational Opcode -> {ext_sel, ext_sel_valid}.
//    The FSM registers its output in S_DECODE.
// TESTING
//  1. Reset release: reset_n 0->1 -> S_IDLE one cycle; Mem_Req=1 on cycle 2, IorD=0, Ext_Sel=0.
//  2. ori (0D), Mem_Ack delayed 3 cycles -> Mem_Req held 3 cycles; Ext_Sel=1 from the cycle after
//     S_DECODE; Reg_Wr=1, Reg_Dst=0 in S_IWB; 6 cycles from first S_FETCH to next S_FETCH.
//  3. lui (0F), then lw (23) -> Ext_Sel 2 during lui, then 0; lw: Mem_Req/IorD=1/Mem_Wr=0 in S_MEM;
//     S_LWB has Reg_Wr=1, MemToReg=1.
//  4. beq with ALU_Zero=1 -> PC_WrCond=1, PC_Src=1; bne with ALU_Zero=1 -> PC_WrCond=0;
//     both return to S_FETCH after 3 cycles.
//  5. Opcode 3F -> Halted=1, Mem_Req stays 0 for 20 cycles; spurious Mem_Ack ignored;
//     reset_n pulse returns the FSM to S_IDLE.
//  6. reset_n asserted during S_MEM of sw -> Mem_Req and Mem_Wr go 0 without waiting for a clock;
//     with PERF_CNT_EN, Retired=0 after reset and increments once per completed instruction.

Source files
------------

// File: rtl/eu_ctrl_pkg.sv
// Purpose: shared encodings for the execution-unit multicycle controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eu_ctrl_pkg;

    // FSM state encoding (4 bits)
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_RX     = 4'd3,
        S_RWB    = 4'd4,
        S_IX     = 4'd5,
        S_IWB    = 4'd6,
        S_ADDR   = 4'd7,
        S_MEM    = 4'd8,
        S_LWB    = 4'd9,
        S_BR     = 4'd10,
        S_JMP    = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Immediate-extend select
    localparam logic [1:0] EXT_SIGN  = 2'd0;
    localparam logic [1:0] EXT_ZERO  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    // ALU operation select
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_OPC   = 2'd3;

    // PC source select
    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;

    // ALU operand B select
    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // Register-immediate ALU instructions (executed through S_IX)
    function automatic logic is_imm_op(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
               (op == OP_ORI)  || (op == OP_XORI) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/eu_ext_sel_decode.sv
// Purpose: maps an opcode to its immediate-extend mode; valid=0 means "keep previous".
// Latency: combinational.
// Backpressure: none.
// Ports: opcode in; ext_sel, ext_sel_valid out.
module eu_ext_sel_decode
    import eu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [1:0] ext_sel,
    output logic       ext_sel_valid
);

    always_comb begin
        ext_sel       = EXT_SIGN;
        ext_sel_valid = 1'b0;
        case (opcode)
            OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE: begin
                ext_sel       = EXT_SIGN;
                ext_sel_valid = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ext_sel       = EXT_ZERO;
                ext_sel_valid = 1'b1;
            end
            OP_LUI: begin
                ext_sel       = EXT_UPPER;
                ext_sel_valid = 1'b1;
            end
            default: begin
                ext_sel       = EXT_SIGN;
                ext_sel_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/eu_multicycle_ctrl.sv
// Purpose: multicycle fetch/decode/execute/mem/writeback control FSM for the EU datapath;
//          owns the single memory port (req/ack) and the registered immediate-extend select.
// Latency: R/imm 4, beq/bne/j 3, sw 4, lw 5 cycles (ack in first request cycle); Mem_Req held until Mem_Ack.
// Ports: clk, reset_n (async low); Opcode/Funct/ALU_Zero/Mem_Ack in; datapath selects/enables,
//        Mem_Req/Mem_Wr, Halted out. Optional macro PERF_CNT_EN adds Retired[CNT_W-1:0].
module eu_multicycle_ctrl
    import eu_ctrl_pkg::*;
#(
    parameter logic [1:0] RESET_PC_SEL = 2'd0,
    parameter int         CNT_W        = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       ALU_Zero,
    input  logic       Mem_Ack,
    output logic       Mem_Req,
    output logic       Mem_Wr,
    output logic       IorD,
    output logic       IR_Wr,
    output logic       PC_Wr,
    output logic       PC_WrCond,
    output logic [1:0] PC_Src,
    output logic       ALU_SrcA,
    output logic [1:0] ALU_SrcB,
    output logic [1:0] ALU_Op,
    output logic [1:0] Ext_Sel,
    output logic       Reg_Wr,
    output logic       Reg_Dst,
    output logic       MemToReg,
    output logic       Halted
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] Retired
`endif
);

    state_t     state_q, state_d;
    logic [1:0] ext_sel_q;
    logic [1:0] ext_dec;
    logic       ext_dec_vld;

    // Funct goes straight to the ALU control block; the FSM never inspects it.
    logic funct_unused;
    assign funct_unused = ^Funct;

    eu_ext_sel_decode u_ext_dec (
        .opcode        (Opcode),
        .ext_sel       (ext_dec),
        .ext_sel_valid (ext_dec_vld)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ext_sel_q <= EXT_SIGN;
        end else begin
            state_q <= state_d;
            // Opcodes without an immediate leave the previous extend mode in place.
            if (state_q == S_DECODE && ext_dec_vld) begin
                ext_sel_q <= ext_dec;
            end
        end
    end

    assign Ext_Sel = ext_sel_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (Mem_Ack) state_d = S_DECODE;
            S_DECODE: begin
                if (Opcode == OP_RTYPE)                       state_d = S_RX;
                else if (is_imm_op(Opcode))                   state_d = S_IX;
                else if (Opcode == OP_LW || Opcode == OP_SW)  state_d = S_ADDR;
                else if (Opcode == OP_BEQ || Opcode == OP_BNE) state_d = S_BR;
                else if (Opcode == OP_J)                      state_d = S_JMP;
                else                                          state_d = S_HALT;
            end
            S_RX:   state_d = S_RWB;
            S_RWB:  state_d = S_FETCH;
            S_IX:   state_d = S_IWB;
            S_IWB:  state_d = S_FETCH;
            S_ADDR: state_d = S_MEM;
            S_MEM: begin
                if (Mem_Ack) state_d = (Opcode == OP_SW) ? S_FETCH : S_LWB;
            end
            S_LWB:  state_d = S_FETCH;
            S_BR:   state_d = S_FETCH;
            S_JMP:  state_d = S_FETCH;
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Moore outputs (IR_Wr/PC_Wr in fetch and PC_WrCond in branch also look at inputs)
    always_comb begin
        Mem_Req   = 1'b0;
        Mem_Wr    = 1'b0;
        IorD      = 1'b0;
        IR_Wr     = 1'b0;
        PC_Wr     = 1'b0;
        PC_WrCond = 1'b0;
        PC_Src    = PCS_ALU;
        ALU_SrcA  = 1'b0;
        ALU_SrcB  = SRCB_B;
        ALU_Op    = ALU_ADD;
        Reg_Wr    = 1'b0;
        Reg_Dst   = 1'b0;
        MemToReg  = 1'b0;
        Halted    = 1'b0;
        case (state_q)
            S_IDLE: PC_Src = RESET_PC_SEL;
            S_FETCH: begin
                Mem_Req  = 1'b1;
                IorD     = 1'b0;
                ALU_SrcA = 1'b0;
                ALU_SrcB = SRCB_FOUR;
                ALU_Op   = ALU_ADD;
                // Latch IR and advance PC only in the cycle the fetch completes.
                if (Mem_Ack) begin
                    IR_Wr  = 1'b1;
                    PC_Wr  = 1'b1;
                    PC_Src = PCS_ALU;
                end
            end
            S_DECODE: begin
                ALU_SrcA = 1'b0;
                ALU_SrcB = SRCB_IMM_SH;
            end
            S_RX: begin
                ALU_SrcA = 1'b1;
                ALU_SrcB = SRCB_B;
                ALU_Op   = ALU_FUNCT;
            end
            S_RWB: begin
                Reg_Wr  = 1'b1;
                Reg_Dst = 1'b1;
            end
            S_IX: begin
                ALU_SrcA = 1'b1;
                ALU_SrcB = SRCB_IMM;
                ALU_Op   = ALU_OPC;
            end
            S_IWB: Reg_Wr = 1'b1;
            S_ADDR: begin
                ALU_SrcA = 1'b1;
                ALU_SrcB = SRCB_IMM;
                ALU_Op   = ALU_ADD;
            end
            S_MEM: begin
                Mem_Req = 1'b1;
                IorD    = 1'b1;
                Mem_Wr  = (Opcode == OP_SW);
            end
            S_LWB: begin
                Reg_Wr   = 1'b1;
                MemToReg = 1'b1;
            end
            S_BR: begin
                ALU_SrcA  = 1'b1;
                ALU_SrcB  = SRCB_B;
                ALU_Op    = ALU_SUB;
                PC_Src    = PCS_ALUOUT;
                PC_WrCond = (Opcode == OP_BEQ) ? ALU_Zero : ~ALU_Zero;
            end
            S_JMP: begin
                PC_Wr  = 1'b1;
                PC_Src = PCS_JUMP;
            end
            S_HALT: Halted = 1'b1;
            default: Halted = 1'b1;
        endcase
    end

`ifdef PERF_CNT_EN
    // One count per completed instruction: any entry into fetch except the
    // first one out of idle. Halt never re-enters fetch, so the count freezes there.
    logic retire_evt;
    assign retire_evt = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Retired <= '0;
        end else if (retire_evt) begin
            Retired <= Retired + 1'b1;
        end
    end
`else
    localparam int cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_eu_multicycle_ctrl.sv
// Purpose: directed-vector bench for eu_multicycle_ctrl with a per-cycle expected-output queue.
// Latency: driver pushes one expectation per cycle at posedge+2; monitor checks at negedge.
// Backpressure: n/a.
module tb_eu_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] Opcode = '0;
    logic [5:0] Funct = '0;
    logic       ALU_Zero = 1'b0;
    logic       Mem_Ack = 1'b0;
    logic       Mem_Req, Mem_Wr, IorD, IR_Wr, PC_Wr, PC_WrCond;
    logic [1:0] PC_Src, ALU_SrcB, ALU_Op, Ext_Sel;
    logic       ALU_SrcA, Reg_Wr, Reg_Dst, MemToReg, Halted;
`ifdef PERF_CNT_EN
    logic [31:0] Retired;
`endif

    always #5 clk = ~clk;

    eu_multicycle_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Opcode    (Opcode),
        .Funct     (Funct),
        .ALU_Zero  (ALU_Zero),
        .Mem_Ack   (Mem_Ack),
        .Mem_Req   (Mem_Req),
        .Mem_Wr    (Mem_Wr),
        .IorD      (IorD),
        .IR_Wr     (IR_Wr),
        .PC_Wr     (PC_Wr),
        .PC_WrCond (PC_WrCond),
        .PC_Src    (PC_Src),
        .ALU_SrcA  (ALU_SrcA),
        .ALU_SrcB  (ALU_SrcB),
        .ALU_Op    (ALU_Op),
        .Ext_Sel   (Ext_Sel),
        .Reg_Wr    (Reg_Wr),
        .Reg_Dst   (Reg_Dst),
        .MemToReg  (MemToReg),
        .Halted    (Halted)
`ifdef PERF_CNT_EN
        ,
        .Retired   (Retired)
`endif
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_wr;
        logic       iord;
        logic       ir_wr;
        logic       pc_wr;
        logic       pc_wrcond;
        logic [1:0] pc_src;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic [1:0] ext;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem2reg;
        logic       halted;
    } ov_t;

    typedef struct {
        ov_t   exp;
        string tag;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    localparam int K_RST = 0, K_IDLE = 1, K_FETCH = 2, K_DEC = 3, K_RX = 4, K_RWB = 5,
                   K_IX = 6, K_IWB = 7, K_ADDR = 8, K_MEM = 9, K_LWB = 10, K_BR = 11,
                   K_JMP = 12, K_HALT = 13;

    // Expected outputs for one cycle in the given phase, written from the control table.
    function automatic ov_t expv(input int k, input bit ack, input bit z,
                                 input logic [5:0] op, input logic [1:0] ext);
        ov_t v;
        v = '0;
        v.ext = ext;
        case (k)
            K_FETCH: begin
                v.mem_req = 1; v.srcb = 2'd1;
                if (ack) begin v.ir_wr = 1; v.pc_wr = 1; end
            end
            K_DEC:  v.srcb = 2'd3;
            K_RX:   begin v.srca = 1; v.srcb = 2'd0; v.aluop = 2'd2; end
            K_RWB:  begin v.reg_wr = 1; v.reg_dst = 1; end
            K_IX:   begin v.srca = 1; v.srcb = 2'd2; v.aluop = 2'd3; end
            K_IWB:  v.reg_wr = 1;
            K_ADDR: begin v.srca = 1; v.srcb = 2'd2; end
            K_MEM:  begin v.mem_req = 1; v.iord = 1; v.mem_wr = (op == 6'h2B); end
            K_LWB:  begin v.reg_wr = 1; v.mem2reg = 1; end
            K_BR: begin
                v.srca = 1; v.aluop = 2'd1; v.pc_src = 2'd1;
                v.pc_wrcond = (op == 6'h04) ? z : !z;
            end
            K_JMP:  begin v.pc_wr = 1; v.pc_src = 2'd2; end
            K_HALT: v.halted = 1;
            default: ;
        endcase
        return v;
    endfunction

    // Drive one cycle of inputs and queue what the DUT should show in that cycle.
    task automatic cyc(input int k, input bit ack, input bit z, input logic [5:0] op,
                       input logic [1:0] ext, input bit rst, input string tag);
        sb_t e;
        @(posedge clk);
        #2;
        reset_n  = rst;
        Mem_Ack  = ack;
        ALU_Zero = z;
        Opcode   = op;
        Funct    = 6'h20;
        e.exp = expv(k, ack, z, op, ext);
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Monitor: compares DUT outputs against the queued expectation each cycle.
    always @(negedge clk) begin
        ov_t got;
        sb_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            got = '{Mem_Req, Mem_Wr, IorD, IR_Wr, PC_Wr, PC_WrCond, PC_Src, ALU_SrcA,
                    ALU_SrcB, ALU_Op, Ext_Sel, Reg_Wr, Reg_Dst, MemToReg, Halted};
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s got=%05h exp=%05h", e.tag, got, e.exp);
            end
        end
    end

`ifdef PERF_CNT_EN
    task automatic chk_ret(input int exp, input string tag);
        checks++;
        if (Retired !== 32'(exp)) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, Retired, exp);
        end
    endtask
`endif

    initial begin
        // Reset held, then released: one idle cycle, then fetch.
        cyc(K_RST,   0, 0, 6'h00, 2'd0, 0, "rst0");
        cyc(K_RST,   0, 0, 6'h00, 2'd0, 0, "rst1");
        cyc(K_IDLE,  0, 0, 6'h00, 2'd0, 1, "idle");
        // ori with ack on the third request cycle
        cyc(K_FETCH, 0, 0, 6'h0D, 2'd0, 1, "ori_f1");
        cyc(K_FETCH, 0, 0, 6'h0D, 2'd0, 1, "ori_f2");
        cyc(K_FETCH, 1, 0, 6'h0D, 2'd0, 1, "ori_f3");
        cyc(K_DEC,   0, 0, 6'h0D, 2'd0, 1, "ori_dec");
        cyc(K_IX,    0, 0, 6'h0D, 2'd1, 1, "ori_ix");
        cyc(K_IWB,   0, 0, 6'h0D, 2'd1, 1, "ori_iwb");
        // lui
        cyc(K_FETCH, 1, 0, 6'h0F, 2'd1, 1, "lui_f");
        cyc(K_DEC,   0, 0, 6'h0F, 2'd1, 1, "lui_dec");
        cyc(K_IX,    0, 0, 6'h0F, 2'd2, 1, "lui_ix");
        cyc(K_IWB,   0, 0, 6'h0F, 2'd2, 1, "lui_iwb");
        // lw, data ack one cycle late
        cyc(K_FETCH, 1, 0, 6'h23, 2'd2, 1, "lw_f");
        cyc(K_DEC,   0, 0, 6'h23, 2'd2, 1, "lw_dec");
        cyc(K_ADDR,  0, 0, 6'h23, 2'd0, 1, "lw_addr");
        cyc(K_MEM,   0, 0, 6'h23, 2'd0, 1, "lw_mem1");
        cyc(K_MEM,   1, 0, 6'h23, 2'd0, 1, "lw_mem2");
        cyc(K_LWB,   0, 0, 6'h23, 2'd0, 1, "lw_wb");
        // R-type
        cyc(K_FETCH, 1, 0, 6'h00, 2'd0, 1, "r_f");
        cyc(K_DEC,   0, 0, 6'h00, 2'd0, 1, "r_dec");
        cyc(K_RX,    0, 0, 6'h00, 2'd0, 1, "r_rx");
        cyc(K_RWB,   0, 0, 6'h00, 2'd0, 1, "r_wb");
        // beq/bne with both zero-flag values
        for (int i = 0; i < 4; i++) begin
            logic [5:0] bop;
            bit         bz;
            bop = (i % 2 == 0) ? 6'h04 : 6'h05;
            bz  = (i < 2);
            cyc(K_FETCH, 1, bz, bop, 2'd0, 1, $sformatf("br%0d_f", i));
            cyc(K_DEC,   0, bz, bop, 2'd0, 1, $sformatf("br%0d_dec", i));
            cyc(K_BR,    0, bz, bop, 2'd0, 1, $sformatf("br%0d_br", i));
        end
        // j
        cyc(K_FETCH, 1, 0, 6'h02, 2'd0, 1, "j_f");
        cyc(K_DEC,   0, 0, 6'h02, 2'd0, 1, "j_dec");
        cyc(K_JMP,   0, 0, 6'h02, 2'd0, 1, "j_jmp");
        // andi
        cyc(K_FETCH, 1, 0, 6'h0C, 2'd0, 1, "andi_f");
        cyc(K_DEC,   0, 0, 6'h0C, 2'd0, 1, "andi_dec");
        cyc(K_IX,    0, 0, 6'h0C, 2'd1, 1, "andi_ix");
        cyc(K_IWB,   0, 0, 6'h0C, 2'd1, 1, "andi_iwb");
        // sw completes
        cyc(K_FETCH, 1, 0, 6'h2B, 2'd1, 1, "sw_f");
        cyc(K_DEC,   0, 0, 6'h2B, 2'd1, 1, "sw_dec");
        cyc(K_ADDR,  0, 0, 6'h2B, 2'd0, 1, "sw_addr");
        cyc(K_MEM,   1, 0, 6'h2B, 2'd0, 1, "sw_mem");
        // illegal opcode traps; spurious acks must not wake it
        cyc(K_FETCH, 1, 0, 6'h3F, 2'd0, 1, "ill_f");
`ifdef PERF_CNT_EN
        chk_ret(11, "retired_11");
`endif
        cyc(K_DEC,   0, 0, 6'h3F, 2'd0, 1, "ill_dec");
        for (int i = 0; i < 20; i++) begin
            cyc(K_HALT, (i % 3 == 0), 0, 6'h3F, 2'd0, 1, $sformatf("halt%0d", i));
        end
        cyc(K_RST,   0, 0, 6'h3F, 2'd0, 0, "halt_rst");
        cyc(K_IDLE,  0, 0, 6'h00, 2'd0, 1, "halt_idle");
        // sw interrupted by reset during the memory request
        cyc(K_FETCH, 1, 0, 6'h2B, 2'd0, 1, "sw2_f");
        cyc(K_DEC,   0, 0, 6'h2B, 2'd0, 1, "sw2_dec");
        cyc(K_ADDR,  0, 0, 6'h2B, 2'd0, 1, "sw2_addr");
        cyc(K_MEM,   0, 0, 6'h2B, 2'd0, 1, "sw2_mem");
        cyc(K_RST,   0, 0, 6'h2B, 2'd0, 0, "sw2_async_rst");
`ifdef PERF_CNT_EN
        chk_ret(0, "retired_rst");
`endif
        cyc(K_IDLE,  0, 0, 6'h00, 2'd0, 1, "post_idle");
        cyc(K_FETCH, 1, 0, 6'h02, 2'd0, 1, "j2_f");
        cyc(K_DEC,   0, 0, 6'h02, 2'd0, 1, "j2_dec");
        cyc(K_JMP,   0, 0, 6'h02, 2'd0, 1, "j2_jmp");
        cyc(K_FETCH, 0, 0, 6'h00, 2'd0, 1, "end_f");
`ifdef PERF_CNT_EN
        chk_ret(1, "retired_1");
`endif
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
